// File: rtl/health_pkg.sv
// Shared types and helpers for the signed reconstructor.
// Holds the FSM state enum, default width and saturation values.
package health_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DATA_WIDTH = 8;

  // Largest positive value for a w-bit two's-complement word (M-1).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative w-bit value (-M).
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// One-bit cell of the serial two's-complement negator.
// Ports: i_bit, i_negative, i_seenOne -> o_result, o_seenOne.
module serial_negate_cell (
  input  logic i_bit,
  input  logic i_negative,
  input  logic i_seenOne,
  output logic o_result,
  output logic o_seenOne
);

  // Copy bits up to and including the first 1, invert after it.
  assign o_result  = i_bit ^ (i_negative & i_seenOne);
  assign o_seenOne = i_seenOne | i_bit;

endmodule

// File: rtl/signed_reconstructor.sv
// Sign/magnitude to two's-complement converter, bit-serial, LSB first.
// Ports: clk, reset (sync, active-high); input side inValid/inReady,
// magnitude, negative; output side outValid/outReady, signedNumber,
// overflow. Optional macro SIGNED_RECONSTRUCTOR_SATURATE_EN clamps
// overflowing results to M-1 / -M.
module signed_reconstructor
  import health_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] magnitude,
  input  logic             negative,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] signedNumber,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_seen;
  logic             r_ovf;
  logic             r_inReady;
  logic             r_outValid;

  logic             w_bit_res;
  logic             w_seen_nxt;
  logic             w_ovf_in;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_final;

  serial_negate_cell u_cell (
    .i_bit      (r_shift[0]),
    .i_negative (r_neg),
    .i_seenOne  (r_seen),
    .o_result   (w_bit_res),
    .o_seenOne  (w_seen_nxt)
  );

  assign w_shift_nxt = {w_bit_res, r_shift[WIDTH-1:1]};

  // Positive overflows at >= M; negative only above M (-M is legal).
  assign w_ovf_in = magnitude[WIDTH-1]
                  & (~negative | (|magnitude[WIDTH-2:0]));

`ifdef SIGNED_RECONSTRUCTOR_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_min(WIDTH));

  assign w_final = r_ovf ? (r_neg ? SAT_NEG : SAT_POS)
                         : w_shift_nxt;
`else
  assign w_final = w_shift_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_out      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_seen     <= 1'b0;
      r_ovf      <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (inValid) begin
            r_shift   <= magnitude;
            r_neg     <= negative;
            r_ovf     <= w_ovf_in;
            r_cnt     <= '0;
            r_seen    <= 1'b0;
            r_inReady <= 1'b0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift <= w_shift_nxt;
          r_seen  <= w_seen_nxt;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_out      <= w_final;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (outReady) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign inReady      = r_inReady;
  assign outValid     = r_outValid;
  assign signedNumber = r_out;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_signed_reconstructor.sv
// Self-checking bench for signed_reconstructor (WIDTH=8).
// Expected results come from an arithmetic model via a queue.
module tb_signed_reconstructor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         inValid;
  logic         outReady;
  logic         negative;
  logic [W-1:0] magnitude;
  logic         inReady;
  logic         outValid;
  logic         overflow;
  logic [W-1:0] signedNumber;

  typedef struct packed {
    logic [W-1:0] d;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  signed_reconstructor #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .inValid      (inValid),
    .inReady      (inReady),
    .magnitude    (magnitude),
    .negative     (negative),
    .outValid     (outValid),
    .outReady     (outReady),
    .signedNumber (signedNumber),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] m, input logic n);
    exp_t e;
    int   big;
    big = 1 << (W - 1);
    if (n) begin
      e.o = (int'(m) > big);
      e.d = W'(-int'(m));
    end else begin
      e.o = (int'(m) >= big);
      e.d = m;
    end
`ifdef SIGNED_RECONSTRUCTOR_SATURATE_EN
    if (e.o) e.d = n ? W'(big) : W'(big - 1);
`endif
    return e;
  endfunction

  task automatic send(input logic [W-1:0] m, input logic n,
                      output bit ok, output int acc);
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      if (inReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      magnitude = m;
      negative  = n;
      inValid   = 1'b1;
      @(posedge clk); #1;
      acc     = cyc;
      inValid = 1'b0;
    end
  endtask

  task automatic wait_out(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      if (outValid === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    negative = 1'b0;
    magnitude = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_chk++;
    if (inReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_inReady: got %b expected 1", inReady);
    end
    n_chk++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outValid: got %b expected 0", outValid);
    end
    n_chk++;
    if (signedNumber !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 00", signedNumber);
    end
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b expected 0", overflow);
    end
  endtask

  task automatic test_values();
    int unsigned vm[11] = '{5, 5, 0, 128, 128, 200, 255, 127, 1, 42, 129};
    bit          vn[11] = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1};
    bit   ok;
    int   acc;
    int   at;
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      send(W'(vm[i]), vn[i], ok, acc);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL val_accept[%0d]: inReady timeout", i);
        continue;
      end
      q.push_back(model(W'(vm[i]), vn[i]));
      wait_out(ok, at);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL val_outValid[%0d]: timeout", i);
        void'(q.pop_front());
        continue;
      end
      e = q.pop_front();
      n_chk++;
      if (at - acc != W) begin
        n_fail++;
        $display("FAIL val_latency[%0d]: got %0d expected %0d",
                 i, at - acc, W);
      end
      n_chk++;
      if (signedNumber !== e.d) begin
        n_fail++;
        $display("FAIL val_data[%0d]: got %h expected %h",
                 i, signedNumber, e.d);
      end
      n_chk++;
      if (overflow !== e.o) begin
        n_fail++;
        $display("FAIL val_ovf[%0d]: got %b expected %b",
                 i, overflow, e.o);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   acc;
    int   at;
    exp_t e;
    send(8'd9, 1'b1, ok, acc);
    q.push_back(model(8'd9, 1'b1));
    wait_out(ok, at);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_outValid: timeout");
    end
    e = q.pop_front();
    magnitude = 8'd3;
    negative  = 1'b0;
    inValid   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (outValid !== 1'b1 || signedNumber !== e.d
          || overflow !== e.o || inReady !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h o=%b r=%b expected v=1 d=%h o=%b r=0",
                 i, outValid, signedNumber, overflow, inReady, e.d, e.o);
      end
    end
    handshake();
    n_chk++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got r=%b v=%b expected r=1 v=0",
               inReady, outValid);
    end
    @(posedge clk); #1;
    acc     = cyc;
    inValid = 1'b0;
    n_chk++;
    if (inReady !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got inReady=%b expected 0", inReady);
    end
    q.push_back(model(8'd3, 1'b0));
    wait_out(ok, at);
    e = q.pop_front();
    n_chk++;
    if (!ok || at - acc != W || signedNumber !== e.d) begin
      n_fail++;
      $display("FAIL bp_next: got ok=%b lat=%0d d=%h expected ok=1 lat=%0d d=%h",
               ok, at - acc, signedNumber, W, e.d);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int acc;
    bit seen;
    send(8'd5, 1'b1, ok, acc);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++;
    if (inReady !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_inReady: got %b expected 1", inReady);
    end
    n_chk++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outValid: got %b expected 0", outValid);
    end
    n_chk++;
    if (signedNumber !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_data: got %h expected 00", signedNumber);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (outValid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_mid_ghost: got outValid=1 expected none");
    end
  endtask

  task automatic test_back_to_back();
    int unsigned vm[3] = '{7, 100, 128};
    bit          vn[3] = '{1, 0, 1};
    bit   ok;
    int   acc;
    int   at;
    int   prev;
    exp_t e;
    outReady = 1'b1;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      send(W'(vm[i]), vn[i], ok, acc);
      q.push_back(model(W'(vm[i]), vn[i]));
      wait_out(ok, at);
      e = q.pop_front();
      n_chk++;
      if (!ok || signedNumber !== e.d || overflow !== e.o) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got ok=%b d=%h o=%b expected ok=1 d=%h o=%b",
                 i, ok, signedNumber, overflow, e.d, e.o);
      end
      if (i > 0) begin
        n_chk++;
        if (at - prev != W + 2) begin
          n_fail++;
          $display("FAIL b2b_spacing[%0d]: got %0d expected %0d",
                   i, at - prev, W + 2);
        end
      end
      prev = at;
    end
    @(posedge clk); #1;
    outReady = 1'b0;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d expected 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
